// File: rtl/sdp_bram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sdp_bram_fifo_ctrl
// Brief    : Synchronous FIFO controller for an external simple-dual-port
//            BRAM. Generates the RAM write/read ports, tracks occupancy and
//            hides the 1-cycle BRAM read latency with a 2-entry registered
//            prefetch buffer. Capacity is DEPTH + 2 words.
//            Optional macro SDP_FIFO_WATERMARK_EN enables registered
//            almost_full / almost_empty flags.
// Revision : 1.0 - initial release
// ============================================================================
module sdp_bram_fifo_ctrl #(
  parameter int ADDR_WIDTH    = 11,
  parameter int DATA_WIDTH    = 32,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic                  r_inflight;
  logic [1:0]            r_buf_cnt;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [ADDR_WIDTH+1:0] r_level;

  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rd_issue;
  logic [2:0]            w_occ;
  logic [ADDR_WIDTH:0]   w_ram_cnt_n;
  logic [1:0]            w_buf_cnt_n;
  logic [DATA_WIDTH-1:0] w_buf0_n;
  logic [DATA_WIDTH-1:0] w_buf1_n;
  logic [ADDR_WIDTH+1:0] w_level_n;

  // Full when wrap bits differ and address bits match; purely registered state.
  assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                   (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
  assign s_ready = ~w_full;

  assign m_valid = (r_buf_cnt != 2'd0);
  assign m_data  = r_buf0;
  assign level   = r_level;

  assign w_push = s_valid & s_ready & ~flush;
  assign w_pop  = m_valid & m_ready;

  // Words that will sit in the buffer (held + arriving) once this cycle's pop
  // is taken; a new read is only issued if it is guaranteed a free slot.
  assign w_occ      = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_issue = (r_ram_cnt != '0) & (w_occ < 3'd2) & ~flush;

  assign ram_ena   = w_push;
  assign ram_wea   = w_push;
  assign ram_addra = r_wr_ptr[ADDR_WIDTH-1:0];
  assign ram_dina  = s_data;
  assign ram_enb   = w_rd_issue;
  assign ram_addrb = r_rd_ptr[ADDR_WIDTH-1:0];

  assign w_ram_cnt_n = r_ram_cnt + (ADDR_WIDTH+1)'(w_push) - (ADDR_WIDTH+1)'(w_rd_issue);

  // Prefetch buffer next state: shift out on pop, then append captured word.
  always_comb begin
    w_buf0_n    = r_buf0;
    w_buf1_n    = r_buf1;
    w_buf_cnt_n = r_buf_cnt;
    if (w_pop) begin
      w_buf0_n    = r_buf1;
      w_buf_cnt_n = r_buf_cnt - 2'd1;
    end
    if (r_inflight) begin
      if (w_buf_cnt_n == 2'd0) begin
        w_buf0_n = ram_doutb;
      end else begin
        w_buf1_n = ram_doutb;
      end
      w_buf_cnt_n = w_buf_cnt_n + 2'd1;
    end
  end

  // Total occupancy after this edge; a flush empties everything.
  assign w_level_n = flush ? '0 :
                     ((ADDR_WIDTH+2)'(w_ram_cnt_n) +
                      (ADDR_WIDTH+2)'(w_rd_issue) +
                      (ADDR_WIDTH+2)'(w_buf_cnt_n));

  // Pointer, counter and prefetch-buffer state; flush restores reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_buf_cnt  <= 2'd0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_level    <= '0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_buf_cnt  <= 2'd0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_level    <= '0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + (ADDR_WIDTH+1)'(w_push);
      r_rd_ptr   <= r_rd_ptr + (ADDR_WIDTH+1)'(w_rd_issue);
      r_ram_cnt  <= w_ram_cnt_n;
      r_inflight <= w_rd_issue;
      r_buf_cnt  <= w_buf_cnt_n;
      r_buf0     <= w_buf0_n;
      r_buf1     <= w_buf1_n;
      r_level    <= w_level_n;
    end
  end

`ifdef SDP_FIFO_WATERMARK_EN
  localparam logic [ADDR_WIDTH+1:0] c_afull  = AFULL_THRESH[ADDR_WIDTH+1:0];
  localparam logic [ADDR_WIDTH+1:0] c_aempty = AEMPTY_THRESH[ADDR_WIDTH+1:0];

  logic r_almost_full;
  logic r_almost_empty;

  // Watermark flags track the same next-level value that loads r_level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b0;
    end else begin
      r_almost_full  <= (w_level_n >= c_afull);
      r_almost_empty <= (w_level_n <= c_aempty);
    end
  end

  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdp_bram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdp_bram_fifo_ctrl
// Brief    : Directed self-checking bench for sdp_bram_fifo_ctrl with an
//            inline BRAM model and an in-order reference queue.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sdp_bram_fifo_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [AW+1:0] level;
  logic          almost_full;
  logic          almost_empty;
  logic          ram_ena;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina;
  logic          ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_doutb = '0;

  logic [DW-1:0] mem [1<<AW];

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];
  int            pop_cnt  = 0;
  logic [DW-1:0] last_pop = '0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always #5 clk = ~clk;

  sdp_bram_fifo_ctrl #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .AFULL_THRESH (12),
    .AEMPTY_THRESH(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .level       (level),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .ram_ena     (ram_ena),
    .ram_wea     (ram_wea),
    .ram_addra   (ram_addra),
    .ram_dina    (ram_dina),
    .ram_enb     (ram_enb),
    .ram_addrb   (ram_addrb),
    .ram_doutb   (ram_doutb)
  );

  // Simple-dual-port BRAM with 1-cycle registered read.
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= mem[ram_addrb];
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: record accepted words, check order and hold on stall.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (flush) begin
          exp_q.delete();
          prev_stall = 1'b0;
        end else begin
          if (prev_stall) begin
            chk("hold_valid", {63'd0, m_valid}, 64'd1);
            chk("hold_data", {32'd0, m_data}, {32'd0, prev_data});
          end
          if (m_valid && m_ready) begin
            chk("pop_has_word", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) chk("pop_data", {32'd0, m_data}, {32'd0, exp_q.pop_front()});
            pop_cnt++;
            last_pop = m_data;
          end
          if (s_valid && s_ready) exp_q.push_back(s_data);
          prev_stall = m_valid && !m_ready;
          prev_data  = m_data;
        end
      end
    end
  end

  initial begin
    int nxt;
    int acc;
    int idle;
    int cyc;

    // ---------------- reset ----------------
    tick(); tick();
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_level", {58'd0, level}, 64'd0);
    chk("rst_ram_enb", {63'd0, ram_enb}, 64'd0);
    chk("rst_m_data", {32'd0, m_data}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
    chk("rst_flags", {62'd0, almost_full, almost_empty}, 64'd0);

    // ---------------- single word latency ----------------
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hA5A5_0001;
    #1;
    chk("lat_ram_ena", {63'd0, ram_ena}, 64'd1);
    chk("lat_ram_addra", {60'd0, ram_addra}, 64'd0);
    tick();                         // edge N
    s_valid = 1'b0;
    #1;
    chk("lat_enb_n1", {63'd0, ram_enb}, 64'd1);
    chk("lat_addrb_n1", {60'd0, ram_addrb}, 64'd0);
    chk("lat_level_n1", {58'd0, level}, 64'd1);
    tick();                         // edge N+1
    chk("lat_mvalid_n1", {63'd0, m_valid}, 64'd0);
    tick();                         // edge N+2
    chk("lat_mvalid_n2", {63'd0, m_valid}, 64'd1);
    chk("lat_mdata_n2", {32'd0, m_data}, 64'hA5A5_0001);
    chk("lat_level_n2", {58'd0, level}, 64'd1);
    tick();                         // popped
    chk("lat_mvalid_pop", {63'd0, m_valid}, 64'd0);
    chk("lat_level_pop", {58'd0, level}, 64'd0);

    // ---------------- fill to capacity ----------------
    m_ready = 1'b0;
    nxt  = 0;
    idle = 0;
    for (int c = 0; c < 60 && idle < 4; c++) begin
      s_valid = 1'b1;
      s_data  = nxt;
      acc     = s_ready ? 1 : 0;
      tick();
      if (acc != 0) nxt++;
      if (!s_ready) idle++;
`ifdef SDP_FIFO_WATERMARK_EN
      chk("wm_afull", {63'd0, almost_full}, {63'd0, level >= 12});
      chk("wm_aempty", {63'd0, almost_empty}, {63'd0, level <= 4});
`endif
    end
    chk("fill_accepted", nxt, 64'd18);
    chk("fill_level", {58'd0, level}, 64'd18);
    chk("fill_s_ready", {63'd0, s_ready}, 64'd0);
    #1;
    chk("fill_no_push", {63'd0, ram_ena}, 64'd0);
    tick();
    chk("fill_level_hold", {58'd0, level}, 64'd18);
    chk("fill_m_data_head", {32'd0, m_data}, 64'd0);
`ifndef SDP_FIFO_WATERMARK_EN
    chk("flags_off", {62'd0, almost_full, almost_empty}, 64'd0);
`else
    chk("wm_full_afull", {63'd0, almost_full}, 64'd1);
    chk("wm_full_aempty", {63'd0, almost_empty}, 64'd0);
`endif

    // ---------------- drain from full with continuous push ----------------
    pop_cnt = 0;
    m_ready = 1'b1;
    cyc = 0;
    while (nxt < 118 && cyc < 200) begin
      s_valid = 1'b1;
      s_data  = nxt;
      acc     = s_ready ? 1 : 0;
      tick();
      if (acc != 0) nxt++;
      cyc++;
    end
    s_valid = 1'b0;
    chk("stream_accepted", nxt, 64'd118);
    for (int c = 0; c < 50 && level != 0; c++) tick();
    chk("stream_drained", {58'd0, level}, 64'd0);
    chk("stream_pop_cnt", pop_cnt, 64'd118);
    chk("stream_last", {32'd0, last_pop}, 64'd117);

    // ---------------- random backpressure ----------------
    pop_cnt = 0;
    nxt = 0;
    cyc = 0;
    while (nxt < 1000 && cyc < 6000) begin
      m_ready = ($urandom % 2) != 0;
      s_valid = 1'b1;
      s_data  = nxt;
      acc     = s_ready ? 1 : 0;
      tick();
      if (acc != 0) nxt++;
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("rand_accepted", nxt, 64'd1000);
    for (int c = 0; c < 60 && level != 0; c++) tick();
    chk("rand_drained", {58'd0, level}, 64'd0);
    chk("rand_pop_cnt", pop_cnt, 64'd1000);
    chk("rand_last", {32'd0, last_pop}, 64'd999);

    // ---------------- flush ----------------
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h100 + i;
      tick();
    end
    chk("flush_pre_level", {58'd0, level}, 64'd10);
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    flush   = 1'b1;
    #1;
    chk("flush_blocks_push", {63'd0, ram_ena}, 64'd0);
    chk("flush_blocks_read", {63'd0, ram_enb}, 64'd0);
    tick();
    flush = 1'b0;
    chk("flush_level", {58'd0, level}, 64'd0);
    chk("flush_m_valid", {63'd0, m_valid}, 64'd0);
    chk("flush_s_ready", {63'd0, s_ready}, 64'd1);
    s_data = 32'h1234;
    tick();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 10 && !m_valid; c++) tick();
    chk("flush_next_valid", {63'd0, m_valid}, 64'd1);
    chk("flush_next_data", {32'd0, m_data}, 64'h1234);
    tick();
    chk("flush_final_level", {58'd0, level}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
